spi_sram_slave: RTL
===================

SPI_SRAM_SLAVE -- requirements
Module: spi_sram_slave

Interface
REQ-001 Parameter DATA_W, default 8: memory word width and data-phase length in bits.
REQ-002 Parameter ADDR_W, default 8: address width and address-phase length in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W: number of words; legal range 2..2**ADDR_W.
REQ-004 SCK  input  1: single clock; all logic on posedge SCK.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 csN  input  1: chip select, active low; a transaction is the span of consecutive posedges with csN=0.
REQ-007 MOSI  input  1: serial data in, sampled on posedge SCK.
REQ-008 MISO  output  1: serial data out, driven from a register bit.
REQ-009 MISO_oe  output  1: high only while a read data phase is active.
REQ-010 cmd_err  output  1: high from the unknown-opcode detection edge until the next transaction starts.

Function
REQ-011 All serial fields SHALL be LSB-first: 8-bit opcode, then ADDR_W-bit address, then DATA_W-bit words.
REQ-012 Opcodes SHALL be 0x02 = WRITE and 0x03 = READ; any other value = unknown.
REQ-013 FSM states SHALL be IDLE, CMD, ADDR, WRITE, READ and IGNORE.
REQ-014 IDLE -> CMD SHALL occur at the first posedge with csN=0; that edge captures opcode bit 0.
REQ-015 CMD -> ADDR SHALL occur on the edge capturing opcode bit 7 for a valid opcode; an unknown opcode SHALL go to IGNORE and set cmd_err on that edge.
REQ-016 ADDR -> WRITE or READ SHALL occur on the edge capturing address bit ADDR_W-1.
REQ-017 An address >= DEPTH SHALL be reduced modulo DEPTH.
REQ-018 WRITE: on the edge capturing bit DATA_W-1 of a word, the word SHALL be written to mem[addr] and addr SHALL increment.
REQ-019 READ, first word: on the edge capturing the last address bit, mem[addr] SHALL load into the TX shift register; MISO = bit 0 from that edge on.
REQ-020 READ, later bits: each following posedge SHALL shift the TX register right.
REQ-021 READ, word boundary: on the edge that would expose bit DATA_W, mem[addr+1] SHALL load instead; bursts are unbounded.
REQ-022 Address increment SHALL wrap from DEPTH-1 to 0 in both READ and WRITE.
REQ-023 IGNORE SHALL hold MISO=0 and MISO_oe=0 until csN=1; MOSI is discarded.
REQ-024 Any posedge with csN=1 SHALL force IDLE and clear bit counters; a partial write word SHALL be discarded, with no memory write.
REQ-025 The master SHALL provide at least one posedge with csN=1 between transactions.
REQ-026 If csN=1 coincides with a word-complete edge, the abort SHALL win and no write occurs.
REQ-027 Outside READ, MISO SHALL be 0 and MISO_oe SHALL be 0.
REQ-028 Memory reads SHALL be combinational from the array; memory writes SHALL be synchronous.

Reset
REQ-029 reset=1 SHALL force IDLE, addr=0, bit counters=0, TX register=0, MISO=0, MISO_oe=0 and cmd_err=0.
REQ-030 reset SHALL take priority over csN, including mid-burst, and SHALL NOT clear memory contents.

Structure
REQ-031 Package spi_sram_pkg SHALL hold the opcode constants and the FSM state typedef.
REQ-032 Storage SHALL be a sub-module sram_array (DATA_W, DEPTH parameters; async read, sync write port).
REQ-033 Bit counter width SHALL be $clog2 of max(8, ADDR_W, DATA_W).

Verification
REQ-034 Single write/read (defaults): WRITE 0x02, addr 0x10, data 0xA5; then READ 0x03, addr 0x10 -> MISO bits 1,0,1,0,0,1,0,1 with MISO_oe=1.
REQ-035 Wrap (DEPTH=4, ADDR_W=2): WRITE burst at addr 3 of 0x11, 0x22 -> mem[3]=0x11, mem[0]=0x22; READ burst from 3 -> 0x11 then 0x22.
REQ-036 Unknown opcode: send 0x55 -> cmd_err=1 on the 8th edge, MISO_oe=0, memory unchanged; next transaction -> cmd_err=0.
REQ-037 Abort: WRITE to addr 0x20, 5 data bits, then csN=1 -> mem[0x20] unchanged; the next transaction decodes its opcode correctly.
REQ-038 Reset mid-burst: assert reset during READ word 2 -> MISO=0 and MISO_oe=0 next edge, state IDLE; previously written data still readable.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared opcode constants, FSM state type and a small sizing helper
// for the SPI SRAM slave.
package spi_sram_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWrite,
        StRead,
        StIgnore
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word-addressed storage: combinational read port, synchronous write port.
// Contents are deliberately not reset.
module sram_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_sram_slave.sv
// SPI-style serial SRAM slave: LSB-first opcode, address and data fields,
// auto-incrementing unbounded read/write bursts, single SCK clock domain.
module spi_sram_slave
    import spi_sram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic SCK,
    input  logic reset,
    input  logic csN,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_oe,
    output logic cmd_err
);

    localparam int unsigned CNT_W  = $clog2(max3(8, ADDR_W, DATA_W));
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wsr_q, wsr_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              err_q, err_d;

    logic [7:0]        op_full;
    logic [ADDR_W-1:0] addr_full, addr_mod, addr_inc;
    logic [DATA_W-1:0] wdata_full, rdata;
    logic [MEM_AW-1:0] raddr;
    logic              we;

    // Each field arrives LSB-first, so shift right and insert at the top.
    assign op_full    = (op_q >> 1) | (8'(MOSI) << 7);
    assign addr_full  = (addr_q >> 1) | (ADDR_W'(MOSI) << (ADDR_W - 1));
    assign wdata_full = (wsr_q >> 1) | (DATA_W'(MOSI) << (DATA_W - 1));
    assign addr_mod   = ADDR_W'({1'b0, addr_full} % DEPTH_L);
    assign addr_inc   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (SCK),
        .we_i    (we),
        .waddr_i (addr_q[MEM_AW-1:0]),
        .wdata_i (wdata_full),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wsr_d   = wsr_q;
        tx_d    = tx_q;
        err_d   = err_q;
        we      = 1'b0;
        raddr   = addr_inc[MEM_AW-1:0];

        // Deselect always wins, even on a word-complete edge.
        if (csN) begin
            state_d = StIdle;
            cnt_d   = '0;
            wsr_d   = '0;
            tx_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCmd;
                    cnt_d   = CNT_W'(1);
                    op_d    = op_full;
                    err_d   = 1'b0;
                    tx_d    = '0;
                end
                StCmd: begin
                    op_d = op_full;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (op_full == OP_WRITE || op_full == OP_READ) begin
                            state_d = StAddr;
                        end else begin
                            state_d = StIgnore;
                            err_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StAddr: begin
                    addr_d = addr_full;
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        addr_d = addr_mod;
                        cnt_d  = '0;
                        if (op_q == OP_READ) begin
                            state_d = StRead;
                            raddr   = addr_mod[MEM_AW-1:0];
                            tx_d    = rdata;
                        end else begin
                            state_d = StWrite;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StWrite: begin
                    wsr_d = wdata_full;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        we     = 1'b1;
                        addr_d = addr_inc;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRead: begin
                    // cnt_q is the index of the bit currently on MISO.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        tx_d   = rdata;
                        addr_d = addr_inc;
                        cnt_d  = '0;
                    end else begin
                        tx_d  = tx_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StIgnore: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge SCK) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wsr_q   <= '0;
            tx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wsr_q   <= wsr_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
        end
    end

    assign MISO_oe = (state_q == StRead);
    assign MISO    = MISO_oe & tx_q[0];
    assign cmd_err = err_q;

endmodule
